// File: rtl/hilo_divu_unit_if.sv
// EX-stage bundle between the pipeline and the Hi/Lo divide unit.
// The master is the EX stage; the slave is hilo_divu_unit.
interface hilo_divu_unit_if #(
    parameter int WIDTH = 32
);
    // Handshake: an instruction is offered whenever en=1, and it is taken at a rising
    // edge only if stall=0 in that cycle. While stall=1 the EX stage must hold
    // en/Signal/dataA/dataB stable, so the held instruction is taken at the first edge
    // with stall=0. stall has no effect when en=0.
    logic             en;
    logic [5:0]       Signal;
    logic [WIDTH-1:0] dataA;
    logic [WIDTH-1:0] dataB;
    logic [WIDTH-1:0] HiOut;
    logic [WIDTH-1:0] LoOut;
    logic             busy;
    logic             done;
    logic             stall;
    logic [1:0]       state_dbg;

    modport master (
        output en, Signal, dataA, dataB,
        input  HiOut, LoOut, busy, done, stall, state_dbg
    );

    modport slave (
        input  en, Signal, dataA, dataB,
        output HiOut, LoOut, busy, done, stall, state_dbg
    );
endinterface

// File: rtl/hilo_divu_unit.sv
// Hi/Lo registers with a multi-cycle unsigned restoring divider for DIVU.
// Define HILO_MTHILO_EN to enable the MTHI/MTLO writes.
module hilo_divu_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic           clk,
    input  logic           rst,
    hilo_divu_unit_if.slave bus
);
    localparam logic [5:0] F_DIVU = 6'd27;
    localparam logic [5:0] F_MFHI = 6'd16;
    localparam logic [5:0] F_MFLO = 6'd18;
`ifdef HILO_MTHILO_EN
    localparam logic [5:0] F_MTHI = 6'd17;
    localparam logic [5:0] F_MTLO = 6'd19;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_WB   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             done_q;

    logic             issue;
    logic             last_step;
    logic [WIDTH:0]   trial;
    logic             take;
    logic [WIDTH-1:0] rem_next;
    logic             hilo_op;

    assign issue     = (state_q == S_IDLE) && bus.en && (bus.Signal == F_DIVU);
    assign last_step = (cnt_q == CNT_W'(WIDTH - 1));

    // The shifted remainder needs one extra bit; when the subtraction happens the
    // result is below the divisor, so the low WIDTH bits are exact.
    assign trial    = {rem_q, quo_q[WIDTH-1]};
    assign take     = (trial >= {1'b0, dvs_q});
    assign rem_next = take ? (trial[WIDTH-1:0] - dvs_q) : trial[WIDTH-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (issue) state_d = S_DIV;
            S_DIV:   if (last_step) state_d = S_WB;
            S_WB:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            quo_q  <= '0;
            rem_q  <= '0;
            dvs_q  <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= (state_q == S_WB);
            case (state_q)
                S_IDLE: begin
                    if (issue) begin
                        quo_q <= bus.dataA;
                        dvs_q <= bus.dataB;
                        rem_q <= '0;
                        cnt_q <= '0;
                    end
`ifdef HILO_MTHILO_EN
                    else if (bus.en && (bus.Signal == F_MTHI)) begin
                        hi_q <= bus.dataA;
                    end else if (bus.en && (bus.Signal == F_MTLO)) begin
                        lo_q <= bus.dataA;
                    end
`endif
                end
                S_DIV: begin
                    // The dividend drains out of the top of quo_q as quotient bits enter below.
                    rem_q <= rem_next;
                    quo_q <= {quo_q[WIDTH-2:0], take};
                    cnt_q <= cnt_q + 1'b1;
                end
                S_WB: begin
                    hi_q <= rem_q;
                    lo_q <= quo_q;
                end
                default: ;
            endcase
        end
    end

`ifdef HILO_MTHILO_EN
    assign hilo_op = (bus.Signal == F_DIVU) || (bus.Signal == F_MFHI) || (bus.Signal == F_MFLO)
                  || (bus.Signal == F_MTHI) || (bus.Signal == F_MTLO);
`else
    assign hilo_op = (bus.Signal == F_DIVU) || (bus.Signal == F_MFHI) || (bus.Signal == F_MFLO);
`endif

    assign bus.busy      = (state_q != S_IDLE);
    assign bus.stall     = bus.busy && bus.en && hilo_op;
    assign bus.done      = done_q;
    assign bus.HiOut     = hi_q;
    assign bus.LoOut     = lo_q;
    assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_hilo_divu_unit.sv
// Directed self-checking bench for hilo_divu_unit; inputs change and outputs are
// sampled on the falling clock edge.
module tb_hilo_divu_unit;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    hilo_divu_unit_if #(.WIDTH(32)) bus ();

    hilo_divu_unit #(.WIDTH(32), .CNT_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic issue_divu(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.en     = 1'b1;
        bus.Signal = 6'd27;
        bus.dataA  = a;
        bus.dataB  = b;
        @(negedge clk);
        bus.en     = 1'b0;
        bus.Signal = 6'd0;
    endtask

    // Counts falling edges spent busy; bounded so a stuck divider still ends the run.
    task automatic wait_idle(output int n, output bit saw_done);
        n = 0;
        saw_done = 1'b0;
        while (bus.busy && n < 60) begin
            if (bus.done) saw_done = 1'b1;
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        checks++; if (bus.HiOut !== 32'd0) begin failures++; $display("FAIL reset_hi got=%h exp=%h", bus.HiOut, 32'd0); end
        checks++; if (bus.LoOut !== 32'd0) begin failures++; $display("FAIL reset_lo got=%h exp=%h", bus.LoOut, 32'd0); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.done); end
        checks++; if (bus.state_dbg !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", bus.state_dbg); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        int n;
        bit early;
        issue_divu(32'd100, 32'd7);
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL basic_busy_start got=%b exp=1", bus.busy); end
        wait_idle(n, early);
        checks++; if (n !== 33) begin failures++; $display("FAIL basic_busy_cycles got=%0d exp=33", n); end
        checks++; if (early !== 1'b0) begin failures++; $display("FAIL basic_done_early got=%b exp=0", early); end
        checks++; if (bus.done !== 1'b1) begin failures++; $display("FAIL basic_done got=%b exp=1", bus.done); end
        checks++; if (bus.HiOut !== 32'd2) begin failures++; $display("FAIL basic_hi got=%h exp=%h", bus.HiOut, 32'd2); end
        checks++; if (bus.LoOut !== 32'd14) begin failures++; $display("FAIL basic_lo got=%h exp=%h", bus.LoOut, 32'd14); end
        @(negedge clk);
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL basic_done_clear got=%b exp=0", bus.done); end
        checks++; if (bus.HiOut !== 32'd2) begin failures++; $display("FAIL basic_hi_hold got=%h exp=%h", bus.HiOut, 32'd2); end
    endtask

    task automatic test_edge_cases;
        int n;
        bit early;
        issue_divu(32'hFFFF_FFFF, 32'd1);
        wait_idle(n, early);
        checks++; if (bus.LoOut !== 32'hFFFF_FFFF) begin failures++; $display("FAIL max_by_one_lo got=%h exp=%h", bus.LoOut, 32'hFFFF_FFFF); end
        checks++; if (bus.HiOut !== 32'd0) begin failures++; $display("FAIL max_by_one_hi got=%h exp=%h", bus.HiOut, 32'd0); end
        issue_divu(32'd5, 32'd9);
        wait_idle(n, early);
        checks++; if (bus.LoOut !== 32'd0) begin failures++; $display("FAIL small_lo got=%h exp=%h", bus.LoOut, 32'd0); end
        checks++; if (bus.HiOut !== 32'd5) begin failures++; $display("FAIL small_hi got=%h exp=%h", bus.HiOut, 32'd5); end
        issue_divu(32'hF000_0001, 32'hF000_0000);
        wait_idle(n, early);
        checks++; if (bus.LoOut !== 32'd1) begin failures++; $display("FAIL wide_div_lo got=%h exp=%h", bus.LoOut, 32'd1); end
        checks++; if (bus.HiOut !== 32'd1) begin failures++; $display("FAIL wide_div_hi got=%h exp=%h", bus.HiOut, 32'd1); end
    endtask

    task automatic test_div_zero;
        int n;
        bit early;
        issue_divu(32'h1234_5678, 32'd0);
        wait_idle(n, early);
        checks++; if (n !== 33) begin failures++; $display("FAIL divzero_cycles got=%0d exp=33", n); end
        checks++; if (bus.done !== 1'b1) begin failures++; $display("FAIL divzero_done got=%b exp=1", bus.done); end
        checks++; if (bus.HiOut !== 32'h1234_5678) begin failures++; $display("FAIL divzero_hi got=%h exp=%h", bus.HiOut, 32'h1234_5678); end
        checks++; if (bus.LoOut !== 32'hFFFF_FFFF) begin failures++; $display("FAIL divzero_lo got=%h exp=%h", bus.LoOut, 32'hFFFF_FFFF); end
    endtask

    task automatic test_ignored;
        // Hi/Lo hold 0x12345678 / 0xFFFFFFFF from the divide-by-zero case.
        @(negedge clk);
        bus.en     = 1'b0;
        bus.Signal = 6'd27;
        bus.dataA  = 32'd40;
        bus.dataB  = 32'd4;
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL bubble_divu_busy got=%b exp=0", bus.busy); end
        bus.en     = 1'b1;
        bus.Signal = 6'd32;
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL other_code_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.LoOut !== 32'hFFFF_FFFF) begin failures++; $display("FAIL other_code_lo got=%h exp=%h", bus.LoOut, 32'hFFFF_FFFF); end
`ifndef HILO_MTHILO_EN
        bus.Signal = 6'd17;
        @(negedge clk);
        checks++; if (bus.HiOut !== 32'h1234_5678) begin failures++; $display("FAIL mthi_ignored_hi got=%h exp=%h", bus.HiOut, 32'h1234_5678); end
`endif
        bus.en     = 1'b0;
        bus.Signal = 6'd0;
    endtask

    task automatic test_back_to_back;
        int  n;
        bit  early;
        bit  held_ok;
        issue_divu(32'd100, 32'd7);
        repeat (3) @(negedge clk);
        bus.en     = 1'b1;
        bus.Signal = 6'd18;
        #1;
        checks++; if (bus.stall !== 1'b1) begin failures++; $display("FAIL stall_mflo got=%b exp=1", bus.stall); end
        bus.en = 1'b0;
        #1;
        checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL stall_bubble got=%b exp=0", bus.stall); end
        bus.Signal = 6'd0;
        bus.en     = 1'b1;
        #1;
        checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL stall_other_code got=%b exp=0", bus.stall); end
        // Held DIVU must stall for the rest of DIV and WB.
        bus.Signal = 6'd27;
        bus.dataA  = 32'd50;
        bus.dataB  = 32'd5;
        held_ok    = 1'b1;
        n          = 0;
        while (bus.busy && n < 60) begin
            #1;
            if (bus.stall !== 1'b1) held_ok = 1'b0;
            n++;
            @(negedge clk);
        end
        checks++; if (held_ok !== 1'b1) begin failures++; $display("FAIL held_divu_stall got=%b exp=1", held_ok); end
        checks++; if (bus.LoOut !== 32'd14) begin failures++; $display("FAIL first_of_pair_lo got=%h exp=%h", bus.LoOut, 32'd14); end
        checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL idle_stall got=%b exp=0", bus.stall); end
        @(negedge clk);
        bus.en     = 1'b0;
        bus.Signal = 6'd0;
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL second_accepted got=%b exp=1", bus.busy); end
        wait_idle(n, early);
        checks++; if (n !== 33) begin failures++; $display("FAIL second_cycles got=%0d exp=33", n); end
        checks++; if (bus.LoOut !== 32'd10) begin failures++; $display("FAIL second_lo got=%h exp=%h", bus.LoOut, 32'd10); end
        checks++; if (bus.HiOut !== 32'd0) begin failures++; $display("FAIL second_hi got=%h exp=%h", bus.HiOut, 32'd0); end
    endtask

    task automatic test_reset_mid;
        int  n;
        bit  early;
        bit  done_seen;
        issue_divu(32'd1000, 32'd3);
        repeat (9) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL midreset_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.LoOut !== 32'd0) begin failures++; $display("FAIL midreset_lo got=%h exp=%h", bus.LoOut, 32'd0); end
        checks++; if (bus.HiOut !== 32'd0) begin failures++; $display("FAIL midreset_hi got=%h exp=%h", bus.HiOut, 32'd0); end
        @(negedge clk);
        rst = 1'b1;
        done_seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done || bus.busy) done_seen = 1'b1;
        end
        checks++; if (done_seen !== 1'b0) begin failures++; $display("FAIL midreset_no_done got=%b exp=0", done_seen); end
        issue_divu(32'd9, 32'd3);
        wait_idle(n, early);
        checks++; if (bus.LoOut !== 32'd3) begin failures++; $display("FAIL after_reset_lo got=%h exp=%h", bus.LoOut, 32'd3); end
        checks++; if (bus.HiOut !== 32'd0) begin failures++; $display("FAIL after_reset_hi got=%h exp=%h", bus.HiOut, 32'd0); end
    endtask

`ifdef HILO_MTHILO_EN
    task automatic test_mthilo;
        int n;
        bit held_ok;
        @(negedge clk);
        bus.en     = 1'b1;
        bus.Signal = 6'd17;
        bus.dataA  = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.en     = 1'b0;
        checks++; if (bus.HiOut !== 32'hDEAD_BEEF) begin failures++; $display("FAIL mthi_hi got=%h exp=%h", bus.HiOut, 32'hDEAD_BEEF); end
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL mthi_done got=%b exp=0", bus.done); end
        issue_divu(32'd7, 32'd2);
        bus.en     = 1'b1;
        bus.Signal = 6'd19;
        bus.dataA  = 32'hCAFE_F00D;
        held_ok    = 1'b1;
        n          = 0;
        while (bus.busy && n < 60) begin
            #1;
            if (bus.stall !== 1'b1) held_ok = 1'b0;
            n++;
            @(negedge clk);
        end
        checks++; if (held_ok !== 1'b1) begin failures++; $display("FAIL mtlo_stall got=%b exp=1", held_ok); end
        checks++; if (bus.LoOut !== 32'd3) begin failures++; $display("FAIL mtlo_pre_lo got=%h exp=%h", bus.LoOut, 32'd3); end
        @(negedge clk);
        bus.en     = 1'b0;
        bus.Signal = 6'd0;
        checks++; if (bus.LoOut !== 32'hCAFE_F00D) begin failures++; $display("FAIL mtlo_lo got=%h exp=%h", bus.LoOut, 32'hCAFE_F00D); end
        checks++; if (bus.HiOut !== 32'd1) begin failures++; $display("FAIL mtlo_hi got=%h exp=%h", bus.HiOut, 32'd1); end
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL mtlo_done got=%b exp=0", bus.done); end
    endtask
`endif

    initial begin
        checks     = 0;
        failures   = 0;
        rst        = 1'b0;
        bus.en     = 1'b0;
        bus.Signal = 6'd0;
        bus.dataA  = 32'd0;
        bus.dataB  = 32'd0;
        #12;
        test_reset();
        test_basic();
        test_edge_cases();
        test_div_zero();
        test_ignored();
        test_back_to_back();
        test_reset_mid();
`ifdef HILO_MTHILO_EN
        test_mthilo();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
